// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: I2S transmitter serialising buffered left/right PCM pairs MSB-first
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int SLOT_BITS = 16,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUMBER_OF_BITS-1:0] data_left,
  input  logic [NUMBER_OF_BITS-1:0] data_right,
  input  logic in_valid,
  output logic in_ready,
  output logic sck,
  output logic ws,
  output logic sd,
  output logic frame_start,
  output logic underrun
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [BW-1:0] LAST = BW'(2 * SLOT_BITS - 1);
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d, idx;
  logic sck_q, sck_d, ws_q, ws_d, sd_q, sd_d, fs_q, fs_d, ur_q, ur_d;
  logic hold_full_q, hold_full_d;
  logic [NUMBER_OF_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [NUMBER_OF_BITS-1:0] left_q, left_d, right_q, right_d, word, sh;
  logic tick, fall, wrap, accept, in_right;
  // divider, frame position, holding register and the next bit/word-select to drive
  always_comb begin
    tick = div_q == DW'(CLK_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    fall = tick & sck_q;
    sck_d = sck_q ^ tick;
    wrap = fall & (bit_q == LAST);
    bit_d = fall ? (bit_q == LAST ? '0 : bit_q + 1'b1) : bit_q;
    accept = in_valid & ~hold_full_q;
    hold_full_d = accept | (hold_full_q & ~wrap);
    hold_l_d = accept ? data_left : hold_l_q;
    hold_r_d = accept ? data_right : hold_r_q;
    left_d = wrap ? (hold_full_q ? hold_l_q : '0) : left_q;
    right_d = wrap ? (hold_full_q ? hold_r_q : '0) : right_q;
    in_right = bit_d >= BW'(SLOT_BITS);
    idx = in_right ? bit_d - BW'(SLOT_BITS) : bit_d;
    word = in_right ? right_d : left_d;
    sh = word << idx;
    sd_d = fall ? sh[NUMBER_OF_BITS-1] : sd_q;
    ws_d = fall ? (bit_d >= BW'(SLOT_BITS - 1)) && (bit_d != LAST) : ws_q;
    fs_d = wrap;
    ur_d = wrap & ~hold_full_q;
  end
  // state registers; reset abandons the frame and discards any held pair
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      bit_q <= LAST;
      sck_q <= 1'b0;
      ws_q <= 1'b0;
      sd_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      left_q <= '0;
      right_q <= '0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      sck_q <= sck_d;
      ws_q <= ws_d;
      sd_q <= sd_d;
      fs_q <= fs_d;
      ur_q <= ur_d;
      hold_full_q <= hold_full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      left_q <= left_d;
      right_q <= right_d;
    end
  end
  assign in_ready = ~hold_full_q;
  assign sck = sck_q;
  assign ws = ws_q;
  assign sd = sd_q;
  assign frame_start = fs_q;
  assign underrun = ur_q;
endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb_pcm_to_i2s: directed table-driven bench for the I2S transmitter
module tb_pcm_to_i2s;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [7:0] data_left = '0, data_right = '0;
  logic in_ready, sck, ws, sd, frame_start, underrun;
  int errors = 0, checks = 0;
  typedef struct {
    logic off;
    logic [7:0] l;
    logic [7:0] r;
    logic [31:0] exp_sd;
    logic exp_ur;
  } vec_t;
  vec_t tbl[6];
  pcm_to_i2s #(.NUMBER_OF_BITS(8), .SLOT_BITS(16), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .data_left(data_left), .data_right(data_right),
    .in_valid(in_valid), .in_ready(in_ready), .sck(sck), .ws(ws), .sd(sd),
    .frame_start(frame_start), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // runs from one frame_start cycle to the next, sampling sd/ws on sck rises
  task automatic capture(input logic off, input logic [7:0] l, input logic [7:0] r,
                         output logic [31:0] sdw, output logic [31:0] wsw, output int len,
                         output int nb, output int acc_at, output logic ur, output logic bad);
    logic ps, psd, acc;
    sdw = '0; wsw = '0; len = 0; nb = 0; acc_at = -1; bad = 1'b0;
    ps = sck; psd = sd;
    if (off) begin
      in_valid = 1'b1; data_left = l; data_right = r;
    end
    for (int i = 0; i < 300; i++) begin
      acc = in_valid & in_ready;
      step();
      len++;
      if (acc) begin
        in_valid = 1'b0;
        acc_at = len;
      end
      if (sd !== psd && !(ps && !sck)) bad = 1'b1;
      if (!ps && sck) begin
        sdw = {sdw[30:0], sd};
        wsw = {wsw[30:0], ws};
        nb++;
      end
      ps = sck; psd = sd;
      if (frame_start) break;
    end
    ur = underrun;
  endtask
  task automatic frame(input string n, input logic off, input logic [7:0] l, input logic [7:0] r,
                       input logic [31:0] exp_sd, input logic exp_ur);
    logic [31:0] sdw, wsw;
    int len, nb, acc_at;
    logic ur, bad;
    capture(off, l, r, sdw, wsw, len, nb, acc_at, ur, bad);
    chk({n, "_sd"}, sdw, exp_sd);
    chk({n, "_ws"}, wsw, 32'h0001FFFE);
    chk({n, "_len"}, 32'(len), 32'd128);
    chk({n, "_bits"}, 32'(nb), 32'd32);
    chk({n, "_ur"}, 32'(ur), 32'(exp_ur));
    chk({n, "_sd_edge"}, 32'(bad), 32'd0);
    chk({n, "_acc_at"}, 32'(acc_at), off ? 32'd1 : 32'hFFFFFFFF);
  endtask
  initial begin
    logic bad;
    tbl[0] = '{1'b1, 8'h81, 8'h7E, 32'hA5003C00, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 8'h00, 32'h81007E00, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 32'hFF000000, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 32'h00000000, 1'b1};
    tbl[4] = '{1'b1, 8'h12, 8'h34, 32'h00000000, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 32'h12003400, 1'b1};
    for (int i = 0; i < 20; i++) begin
      step();
      chk("reset_outs", 32'({sck, ws, sd, frame_start, underrun, in_ready}), 32'b000001);
    end
    reset = 1'b0; in_valid = 1'b1; data_left = 8'hA5; data_right = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("first_accept_ready", 32'(in_ready), 32'd0);
    chk("clk1_sck", 32'(sck), 32'd0);
    step();
    chk("clk2_sck_fs", 32'({sck, frame_start}), 32'b10);
    step();
    chk("clk3_fs", 32'(frame_start), 32'd0);
    step();
    chk("clk4_fs_ur_sd_ws_sck", 32'({frame_start, underrun, sd, ws, sck}), 32'b10100);
    for (int i = 0; i < 6; i++)
      frame($sformatf("tbl%0d", i), tbl[i].off, tbl[i].l, tbl[i].r, tbl[i].exp_sd, tbl[i].exp_ur);
    in_valid = 1'b1; data_left = 8'h81; data_right = 8'h7E;
    step();
    chk("p0_acc_ready", 32'(in_ready), 32'd0);
    data_left = 8'hFF; data_right = 8'h00;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (frame_start) break;
      if (in_ready) bad = 1'b1;
    end
    chk("p1_stall", 32'(bad), 32'd0);
    chk("p0_fs_seen", 32'(frame_start), 32'd1);
    chk("p0_fs_ready_ur", 32'({in_ready, underrun}), 32'b10);
    frame("p0", 1'b1, 8'hFF, 8'h00, 32'h81007E00, 1'b0);
    frame("p1", 1'b0, 8'h00, 8'h00, 32'hFF000000, 1'b1);
    for (int i = 0; i < 127; i++) step();
    in_valid = 1'b1; data_left = 8'h55; data_right = 8'hAA;
    step();
    in_valid = 1'b0;
    chk("simul_fs_ur_ready", 32'({frame_start, underrun, in_ready}), 32'b110);
    frame("simul_zero", 1'b0, 8'h00, 8'h00, 32'h00000000, 1'b0);
    frame("simul_next", 1'b0, 8'h00, 8'h00, 32'h5500AA00, 1'b1);
    in_valid = 1'b1; data_left = 8'h11; data_right = 8'h22;
    step();
    in_valid = 1'b0;
    chk("mid_hold_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 79; i++) step();
    chk("mid_pre_rst_ws", 32'(ws), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_outs", 32'({sck, ws, sd, frame_start, underrun, in_ready}), 32'b000001);
    reset = 1'b0;
    step();
    chk("mid_clk1_sck", 32'(sck), 32'd0);
    step();
    chk("mid_clk2_sck", 32'(sck), 32'd1);
    step();
    step();
    chk("mid_clk4_fs_ur", 32'({frame_start, underrun}), 32'b11);
    frame("mid_after", 1'b0, 8'h00, 8'h00, 32'h00000000, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pcm_to_i2s.md
Name: pcm_to_i2s

Overview:
I2S transmitter, the send-side counterpart of our I2S-to-PCM receiver. It accepts parallel left/right PCM sample pairs over a valid/ready handshake into a one-entry holding register. It serialises each pair MSB-first onto an I2S bus (sck, ws, sd) that it generates itself from the system clock. It sits between the channel buffer/DSP path and the output pins, and can be looped back into the receiver for self-test.

Parameters:
NUMBER_OF_BITS, 8, sample width per channel
SLOT_BITS, 16, sck periods per channel slot; must be >= NUMBER_OF_BITS and >= 2
CLK_DIV, 2, clk cycles per sck half-period; must be >= 1

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
data_left  input  NUMBER_OF_BITS  left sample (ws=0 slot)
data_right  input  NUMBER_OF_BITS  right sample (ws=1 slot)
in_valid  input  1  sample pair present on data_left/data_right
in_ready  output  1  holding register empty; pair accepted when in_valid & in_ready at posedge
sck  output  1  I2S bit clock, registered
ws  output  1  I2S word select, registered, 0 = left
sd  output  1  I2S serial data, registered, changes only with sck falling
frame_start  output  1  one-clk pulse when a new frame's left MSB is driven
underrun  output  1  one-clk pulse when a frame starts with the holding register empty

Behaviour:
- Reset values: sck=0, ws=0, sd=0, in_ready=1, frame_start=0, underrun=0; div_cnt=0; bit_cnt=2*SLOT_BITS-1; holding register empty; shift registers zero.
- Divider: div_cnt increments every clk and wraps at CLK_DIV-1. On the wrap cycle sck toggles, giving an sck period of 2*CLK_DIV clk.
- Rising sck (0->1): no data change. The receiver samples here.
- Falling sck (1->0) is a shift event:
  - bit_cnt advances and wraps from 2*SLOT_BITS-1 to 0.
  - ws and sd are updated in the same clk edge as sck.
- Frame layout by bit_cnt b:
  - b < SLOT_BITS: sd = left_shift[NUMBER_OF_BITS-1-b] if b < NUMBER_OF_BITS, else 0.
  - b >= SLOT_BITS: same rule on right_shift with b-SLOT_BITS.
  - ws = 1 for b in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0. This is the standard I2S one-bit ws lead.
- Frame start (shift event with bit_cnt wrapping to 0):
  - If the holding register is full: copy it into left_shift/right_shift, mark it empty. in_ready=1 from the next cycle.
  - If empty: load zeros into both shift registers and pulse underrun.
  - frame_start pulses in the same cycle as sck falls and sd shows the left MSB.
- First frame after reset: first rising sck at clk CLK_DIV after reset release. First falling sck / frame_start at clk 2*CLK_DIV.
- Handshake:
  - in_ready = !hold_full.
  - An accept sets hold_full; the pair is captured on that edge.
  - in_valid while in_ready=0 is ignored; the upstream block holds the data.
- Simultaneous accept and frame start with hold empty: that frame underruns and transmits zeros. The accepted pair goes to the holding register for the next frame.
- Samples already loaded into the shift registers are never altered by a later accept.
- Reset mid-frame: all state returns to reset values on the next edge, and the partial frame is abandoned. The holding-register contents are discarded, so in_ready=1.

Test Plan:
- Reset with in_valid=0 for 20 clk -> sck/ws/sd/frame_start/underrun all 0 and in_ready=1 throughout reset.
- Defaults; after reset accept left=0xA5, right=0x3C at clk 1 -> frame_start at clk 4.
  - sd at successive sck rises: 1,0,1,0,0,1,0,1, then 8 zeros, then 0,0,1,1,1,1,0,0, then 8 zeros.
  - ws rises at the falling edge before right bit 0 (bit 15) and falls at bit 31.
  - frame length 128 clk.
- No data offered -> every frame_start coincides with an underrun pulse, sd stays 0, and ws still toggles with a 128-clk period.
- Offer pairs P0=(0x81,0x7E) and P1=(0xFF,0x00) back to back:
  - P0 accepted; in_ready drops; P1 stalls.
  - P0 loads at frame start; P1 is accepted the cycle after frame start.
  - Frame 2 carries P1 with no underrun.
- Assert in_valid with pair (0x55,0xAA) exactly on the frame_start cycle with hold empty -> underrun=1 that cycle and that frame is all zeros; the next frame carries 0x55/0xAA.
- Pulse reset at bit_cnt=20 with a pair held -> next cycle sck=ws=sd=0 and in_ready=1; the first post-reset frame underruns; frame timing restarts from 2*CLK_DIV.
